// File: rtl/video_src_switch_ctrl.sv
// Frame-aligned two-source AXI4-Stream arbiter with a registered 2-entry output slice.
// Sources change only on start-of-frame (TUSER[0]), so the output never carries a spliced frame.
module video_src_switch_ctrl #(
    parameter int unsigned DW      = 32,
    parameter int unsigned SYNC_TO = 1048576,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             axi_clk_i,
    input  logic             axi_rst_i,
    input  logic             enable_i,
    input  logic             sel_i,
    input  logic             drain_unsel_i,
    input  logic [DW-1:0]    in0_tdata_i,
    input  logic             in0_tvalid_i,
    output logic             in0_tready_o,
    input  logic             in0_tuser_i,
    input  logic             in0_tlast_i,
    input  logic [DW-1:0]    in1_tdata_i,
    input  logic             in1_tvalid_i,
    output logic             in1_tready_o,
    input  logic             in1_tuser_i,
    input  logic             in1_tlast_i,
    output logic [DW-1:0]    out_tdata_o,
    output logic             out_tvalid_o,
    input  logic             out_tready_i,
    output logic             out_tuser_o,
    output logic             out_tlast_o,
    output logic             cur_sel_o,
    output logic             switching_o,
    output logic             sync_err_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int unsigned TO_W = $clog2(SYNC_TO + 1);

    typedef enum logic [1:0] {
        ST_SYNC     = 2'd0,
        ST_PASS     = 2'd1,
        ST_WAIT_EOF = 2'd2
    } state_t;

    state_t          state;
    logic            cur_sel;
    logic            slice_rdy;
    logic            skid_vld;
    logic [DW-1:0]   skid_data;
    logic            skid_user;
    logic            skid_last;
    logic [TO_W-1:0] to_cnt;

    logic [DW-1:0]   hd_data;
    logic            hd_vld;
    logic            hd_user;
    logic            hd_last;
    logic            hd_rdy;
    logic            hd_acc;
    logic            push;
    logic            drop;
    logic            pop;
    logic [1:0]      occ;
    logic [1:0]      occ_nxt;

    // Head beat of the source that currently owns the output
    always_comb begin
        hd_data = cur_sel ? in1_tdata_i  : in0_tdata_i;
        hd_vld  = cur_sel ? in1_tvalid_i : in0_tvalid_i;
        hd_user = cur_sel ? in1_tuser_i  : in0_tuser_i;
        hd_last = cur_sel ? in1_tlast_i  : in0_tlast_i;
    end

    // Selected-source ready: SOF is held off in WAIT_EOF, non-SOF beats are flushed in SYNC
    always_comb begin
        hd_rdy = 1'b0;
        case (state)
            ST_PASS:     hd_rdy = enable_i & slice_rdy;
            ST_WAIT_EOF: hd_rdy = enable_i & slice_rdy & ~(hd_vld & hd_user);
            default:     hd_rdy = enable_i & (hd_user ? (slice_rdy & (sel_i == cur_sel)) : 1'b1);
        endcase
    end

    assign in0_tready_o = cur_sel ? drain_unsel_i : hd_rdy;
    assign in1_tready_o = cur_sel ? hd_rdy : drain_unsel_i;

    assign hd_acc  = hd_vld & hd_rdy;
    assign push    = hd_acc & ((state != ST_SYNC) | hd_user);
    assign drop    = hd_acc & (state == ST_SYNC) & ~hd_user;
    assign pop     = out_tvalid_o & out_tready_i;
    assign occ     = 2'(out_tvalid_o) + 2'(skid_vld);
    assign occ_nxt = occ + 2'(push) - 2'(pop);

    assign cur_sel_o   = cur_sel;
    assign switching_o = (state != ST_PASS);

    // Output register plus skid entry; ready is registered from next occupancy
    always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
        if (axi_rst_i) begin
            out_tvalid_o <= 1'b0;
            out_tdata_o  <= '0;
            out_tuser_o  <= 1'b0;
            out_tlast_o  <= 1'b0;
            skid_vld     <= 1'b0;
            skid_data    <= '0;
            skid_user    <= 1'b0;
            skid_last    <= 1'b0;
            slice_rdy    <= 1'b0;
        end else begin
            slice_rdy <= ~occ_nxt[1];
            if (!out_tvalid_o || out_tready_i) begin
                if (skid_vld) begin
                    out_tvalid_o <= 1'b1;
                    out_tdata_o  <= skid_data;
                    out_tuser_o  <= skid_user;
                    out_tlast_o  <= skid_last;
                    skid_vld     <= push;
                    if (push) begin
                        skid_data <= hd_data;
                        skid_user <= hd_user;
                        skid_last <= hd_last;
                    end
                end else begin
                    out_tvalid_o <= push;
                    if (push) begin
                        out_tdata_o <= hd_data;
                        out_tuser_o <= hd_user;
                        out_tlast_o <= hd_last;
                    end
                end
            end else if (push) begin
                skid_vld  <= 1'b1;
                skid_data <= hd_data;
                skid_user <= hd_user;
                skid_last <= hd_last;
            end
        end
    end

    // Switch FSM with SOF-wait timeout; sync_err clears when PASS is entered
    always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
        if (axi_rst_i) begin
            state      <= ST_SYNC;
            cur_sel    <= 1'b0;
            to_cnt     <= '0;
            sync_err_o <= 1'b0;
        end else begin
            case (state)
                ST_PASS: begin
                    to_cnt <= '0;
                    if (!enable_i) begin
                        state <= ST_SYNC;
                    end else if (sel_i != cur_sel) begin
                        state <= ST_WAIT_EOF;
                    end
                end
                ST_WAIT_EOF: begin
                    to_cnt <= '0;
                    if (!enable_i) begin
                        state   <= ST_SYNC;
                        cur_sel <= sel_i;
                    end else if (hd_vld && hd_user) begin
                        state   <= ST_SYNC;
                        cur_sel <= ~cur_sel;
                    end else if (sel_i == cur_sel) begin
                        state <= ST_PASS;
                    end
                end
                default: begin
                    if (enable_i && (sel_i != cur_sel)) begin
                        cur_sel <= sel_i;
                        to_cnt  <= '0;
                    end else begin
                        if (enable_i && (to_cnt != TO_W'(SYNC_TO))) begin
                            to_cnt <= to_cnt + TO_W'(1);
                            if (to_cnt == TO_W'(SYNC_TO - 1)) begin
                                sync_err_o <= 1'b1;
                            end
                        end
                        if (push) begin
                            state      <= ST_PASS;
                            sync_err_o <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Frame counter wraps, drop counter saturates
    always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
        if (axi_rst_i) begin
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else begin
            if (push && hd_user) begin
                frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end
            if (drop && (drop_cnt_o != {CNT_W{1'b1}})) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
